// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with clear sequencer, pending-write scoreboard and optional bypass
module register_file_sb #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5,
    parameter int RD_PORTS    = 2,
    parameter int BYPASS      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [RD_PORTS*REG_NUM_BIT-1:0] raddr,
    output logic [RD_PORTS*DATA_WIDTH-1:0]  rdata,
    output logic [RD_PORTS-1:0]             rbusy,
    input  logic                            wen,
    input  logic [REG_NUM_BIT-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            alloc_en,
    input  logic [REG_NUM_BIT-1:0]          alloc_addr,
    input  logic                            clear_req,
    output logic                            ready
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [REG_NUM_BIT:0]   NUM  = (REG_NUM_BIT+1)'(REG_NUM);
    localparam logic [REG_NUM_BIT-1:0] LAST = REG_NUM_BIT'(REG_NUM - 1);

    logic [0:0]             state_q, state_d;
    logic [REG_NUM_BIT-1:0] clr_cnt_q, clr_cnt_d;
    logic [REG_NUM-1:0]     busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  rf [REG_NUM];
    logic                   run, w_ok, a_ok;

    assign run   = state_q == RUN;
    assign ready = run;
    assign w_ok  = run && wen && waddr != '0 && {1'b0, waddr} < NUM;
    assign a_ok  = run && alloc_en && alloc_addr != '0 && {1'b0, alloc_addr} < NUM;

    // Sequencer: walk every register once in INIT, re-enter INIT on a clear request
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (!run) begin
            clr_cnt_d = clr_cnt_q == LAST ? '0 : clr_cnt_q + 1'b1;
            state_d   = clr_cnt_q == LAST ? RUN : INIT;
        end else if (clear_req) begin
            state_d = INIT;
        end
    end

    // Scoreboard: writeback clears, allocation sets afterwards so the newest producer wins
    always_comb begin
        busy_d = busy_q;
        if (run && clear_req) begin
            busy_d = '0;
        end else begin
            if (w_ok) busy_d[waddr] = 1'b0;
            if (a_ok) busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control state with asynchronous reset back to the start of the clear sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Storage array: zeroed one entry per cycle by the sequencer, otherwise written by writeback
    always_ff @(posedge clk) begin
        if (!run) rf[clr_cnt_q] <= '0;
        else if (w_ok) rf[waddr] <= wdata;
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        logic [REG_NUM_BIT-1:0] ra;
        logic                   hit, fwd;
        assign ra = raddr[i*REG_NUM_BIT +: REG_NUM_BIT];
        assign hit = run && ra != '0 && {1'b0, ra} < NUM;
        assign fwd = (BYPASS != 0) && w_ok && waddr == ra;
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = !hit ? '0 : fwd ? wdata : rf[ra];
        assign rbusy[i] = hit && !fwd && busy_q[ra];
    end
endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised multi-read-port integer register file with a built-in clear sequencer, a pending-write scoreboard and optional write-to-read bypass. It sits in the decode/writeback path of the core. Decode reads operands and allocates destination registers. Writeback retires results. Issue logic stalls on the per-port busy flags.

## Interface
- DATA_WIDTH, 32, bits per register
- REG_NUM, 32, number of architectural registers (register 0 hardwired to zero)
- REG_NUM_BIT, 5, address width; REG_NUM <= 2**REG_NUM_BIT
- RD_PORTS, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to matching read ports; 0 = no forwarding

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- raddr  in  RD_PORTS*REG_NUM_BIT  read addresses, port i at bits [i*REG_NUM_BIT +: REG_NUM_BIT]
- rdata  out  RD_PORTS*DATA_WIDTH  read data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- rbusy  out  RD_PORTS  port i addresses a register with an outstanding write
- wen  in  1  writeback enable
- waddr  in  REG_NUM_BIT  writeback address
- wdata  in  DATA_WIDTH  writeback data
- alloc_en  in  1  mark alloc_addr as pending (new producer issued)
- alloc_addr  in  REG_NUM_BIT  register being allocated
- clear_req  in  1  single-cycle request to re-zero the whole file
- ready  out  1  file initialised; reads, writes and allocations valid

## Operation
- FSM states:
  - INIT: clear sequencer active.
  - RUN: normal operation.
- Clear sequencer:
  - Counter clr_cnt (REG_NUM_BIT bits).
  - Each INIT cycle writes 0 to rf[clr_cnt] and increments clr_cnt.
  - When clr_cnt == REG_NUM-1 is written, go to RUN on that edge and reset clr_cnt to 0.
- Entry to INIT:
  - rst assertion (asynchronous) → INIT, clr_cnt=0, all busy bits 0, ready=0.
  - clear_req sampled high in RUN → INIT on next edge; all busy bits cleared on the same edge.
  - clear_req while already in INIT is ignored; the sequence does not restart.
- During INIT:
  - wen and alloc_en are ignored.
  - rdata is all zeros and rbusy is all zeros.
- Writes (RUN only):
  - wen=1 with waddr != 0 writes wdata to rf[waddr] on the rising edge.
  - waddr == 0 is discarded.
  - waddr >= REG_NUM is discarded.
- Reads (combinational):
  - rdata_i = 0 if raddr_i == 0 or raddr_i >= REG_NUM.
  - Otherwise, if BYPASS=1, wen=1 and waddr == raddr_i, rdata_i = wdata.
  - Otherwise rdata_i = rf[raddr_i].
- Scoreboard: REG_NUM busy bits; busy[0] is constant 0.
  - alloc_en=1 (RUN, alloc_addr != 0) sets busy[alloc_addr].
  - wen=1 (RUN, waddr != 0) clears busy[waddr].
  - alloc_en and wen on the same address in the same cycle: the bit ends set, because the newest producer is outstanding.
- rbusy:
  - rbusy_i = busy[raddr_i], except forced 0 when the BYPASS=1 forward condition hits on port i.
  - raddr_i == 0 gives rbusy_i = 0.
- Out-of-range alloc_addr (>= REG_NUM) is ignored.

## Timing
- Reset values:
  - ready=0, state INIT, clr_cnt=0, busy all 0.
  - rdata=0 and rbusy=0 while in INIT.
- ready is registered. After rst deasserts, ready rises after exactly REG_NUM rising edges (32 by default).
- After clear_req, ready drops on the next edge. It rises again REG_NUM edges later, giving REG_NUM+1 edges from the clear_req sample edge.
- Write-to-read latency:
  - 0 cycles with BYPASS=1 (same cycle).
  - 1 cycle with BYPASS=0 (visible after the write edge).
- Scoreboard latency:
  - alloc visible on rbusy the cycle after alloc_en.
  - A clear is visible the cycle after wen, or the same cycle via bypass masking.
- rst asserted mid-INIT or mid-RUN: immediate return to the reset state; the sequence restarts from register 0 after deassert.
- Array contents are not reset asynchronously; only the sequencer zeroes them.

## Test plan
- Reset then idle: assert rst 3 cycles, release → ready=0 for 32 edges, then 1; every port reads 0 at every address 0..31.
- Write/readback, BYPASS=1:
  - wen=1, waddr=5, wdata=0xDEADBEEF, raddr0=5 in the same cycle → rdata0=0xDEADBEEF that cycle.
  - Next cycle, raddr1=5 → 0xDEADBEEF.
  - With BYPASS=0 the same-cycle read returns 0.
- Register 0: wen=1, waddr=0, wdata=0xFFFFFFFF, alloc_en=1, alloc_addr=0 → rdata=0 and rbusy=0 on all ports.
- Scoreboard:
  - alloc_addr=7 → rbusy0=1 next cycle for raddr0=7.
  - wen to 7 with BYPASS=1 → rbusy0=0 that cycle.
  - Same-cycle alloc_en=1 and wen=1 on 9 → rbusy=1 after the edge.
- clear_req in RUN after writing 0x1234 to reg 3 and allocating reg 4:
  - ready=0 next cycle; busy cleared.
  - After 32 edges ready=1, rf[3] reads 0, and wen during INIT had no effect.
- Mid-clear reset: assert rst while clr_cnt=10 → ready stays 0; the sequence restarts and ready rises 32 edges after release.
